// File: rtl/dense_layer.sv
// dense_layer: fully connected stage fed by the pooled-feature split RAM.
//
// For each neuron o the block streams the IN_ADDRS feature addresses and the
// matching weight ROM words. It multiplies NUM_RAM_SPLITS lanes in parallel and
// accumulates the lane sums. It then applies bias, optional ReLU and signed
// saturation, and writes one BIT_WIDTH word per neuron to the output RAM.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset
//   start      begin a full layer pass (sampled in IDLE only)
//   addr_rd    feature RAM read address (k)
//   data_rd    feature words, lane i at [i*BIT_WIDTH +: BIT_WIDTH]
//   w_addr_rd  weight ROM address (o*IN_ADDRS + k)
//   w_data_rd  weight words, same lane packing
//   bias_addr  bias ROM address (o)
//   bias_rd    bias word
//   addr_wr    output RAM write address (neuron index)
//   data_wr    output word
//   wren       output write strobe
//   busy       high from the first FETCH through the last WRITE
//   done       one-cycle pulse after the final write
//
// All memories have a one-cycle read latency.

module dense_layer #(
   parameter int NUM_INPUTS     = 180,
   parameter int NUM_OUTPUTS    = 32,
   parameter int BIT_WIDTH      = 16,
   parameter int NUM_RAM_SPLITS = 7,
   parameter int FRAC_BITS      = 8,
   parameter int ACC_WIDTH      = 40,
   parameter int RELU           = 1,
   localparam int IN_ADDRS = (NUM_INPUTS + NUM_RAM_SPLITS - 1) / NUM_RAM_SPLITS,
   localparam int AddrW    = (IN_ADDRS > 1) ? $clog2(IN_ADDRS) : 1,
   localparam int WAddrW   = (NUM_OUTPUTS * IN_ADDRS > 1) ? $clog2(NUM_OUTPUTS * IN_ADDRS) : 1,
   localparam int OutW     = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   output logic [AddrW-1:0]                    addr_rd,
   input  logic [BIT_WIDTH*NUM_RAM_SPLITS-1:0] data_rd,
   output logic [WAddrW-1:0]                   w_addr_rd,
   input  logic [BIT_WIDTH*NUM_RAM_SPLITS-1:0] w_data_rd,
   output logic [OutW-1:0]                     bias_addr,
   input  logic [BIT_WIDTH-1:0]                bias_rd,
   output logic [OutW-1:0]                     addr_wr,
   output logic [BIT_WIDTH-1:0]                data_wr,
   output logic                                wren,
   output logic                                busy,
   output logic                                done
);

   localparam int ProdW = 2 * BIT_WIDTH;
   // Number of real features carried by the last address; lanes at or above
   // this index on that address are padding.
   localparam int LastLanes = NUM_INPUTS - (IN_ADDRS - 1) * NUM_RAM_SPLITS;

   localparam logic signed [ACC_WIDTH-1:0] SatMax =
      {{(ACC_WIDTH - BIT_WIDTH + 1){1'b0}}, {(BIT_WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SatMin =
      {{(ACC_WIDTH - BIT_WIDTH + 1){1'b1}}, {(BIT_WIDTH - 1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StFetch, StDrain, StWrite, StDone} state_e;

   state_e state_q, state_d;

   logic [AddrW-1:0] k_q;
   logic [OutW-1:0]  o_q;
   logic             drain_q;   // 0 in the first DRAIN cycle, 1 in the second
   logic             k_last, o_last;

   logic rd_valid_q;            // data_rd/w_data_rd carry a FETCH response
   logic rd_last_q;             // ...and it belongs to the last address

   logic signed [BIT_WIDTH-1:0] x_lane [NUM_RAM_SPLITS];
   logic signed [BIT_WIDTH-1:0] w_lane [NUM_RAM_SPLITS];
   logic signed [ProdW-1:0]     prod_d [NUM_RAM_SPLITS];
   logic signed [ProdW-1:0]     prod_q [NUM_RAM_SPLITS];

   logic signed [ACC_WIDTH-1:0] lane_sum, acc_q;
   logic signed [ACC_WIDTH-1:0] acc_shr, res_full;
   logic signed [BIT_WIDTH-1:0] bias_q;
   logic [BIT_WIDTH-1:0]        res;
   logic                        acc_clr;

   logic [BIT_WIDTH-1:0] data_wr_q;
   logic [OutW-1:0]      addr_wr_q;

   always_comb begin
      k_last = (k_q == AddrW'(IN_ADDRS - 1));
      o_last = (o_q == OutW'(NUM_OUTPUTS - 1));
   end

   // ---------------------------------------------------------------- FSM

   always_ff @(posedge clk) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StFetch;
         StFetch: if (k_last) state_d = StDrain;
         StDrain: if (drain_q) state_d = StWrite;
         StWrite: state_d = o_last ? StDone : StFetch;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wren      = (state_q == StWrite);
      busy      = (state_q == StFetch) || (state_q == StDrain) || (state_q == StWrite);
      done      = (state_q == StDone);
      addr_rd   = k_q;
      bias_addr = o_q;
      w_addr_rd = WAddrW'(int'(o_q) * IN_ADDRS + int'(k_q));
      // Outputs hold the last written value between writes.
      data_wr   = wren ? res : data_wr_q;
      addr_wr   = wren ? o_q : addr_wr_q;
   end

   // ----------------------------------------------------------- counters

   always_ff @(posedge clk) begin
      if (!rst) begin
         k_q     <= '0;
         o_q     <= '0;
         drain_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               k_q     <= '0;
               o_q     <= '0;
               drain_q <= 1'b0;
            end
            StFetch: k_q <= k_last ? '0 : k_q + 1'b1;
            StDrain: drain_q <= ~drain_q;
            StWrite: if (!o_last) o_q <= o_q + 1'b1;
            StDone:  o_q <= '0;
            default: ;
         endcase
      end
   end

   // ----------------------------------------------------------- datapath

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         rd_valid_q <= (state_q == StFetch);
         rd_last_q  <= (state_q == StFetch) && k_last;
      end
   end

   // Stage 1: lane products; padded lanes and non-FETCH cycles contribute 0.
   always_comb begin
      for (int i = 0; i < NUM_RAM_SPLITS; i++) begin
         x_lane[i] = data_rd[i*BIT_WIDTH +: BIT_WIDTH];
         w_lane[i] = w_data_rd[i*BIT_WIDTH +: BIT_WIDTH];
         prod_d[i] = '0;
         if (rd_valid_q && (!rd_last_q || (i < LastLanes))) begin
            prod_d[i] = ProdW'(x_lane[i]) * ProdW'(w_lane[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_RAM_SPLITS; i++) begin
         if (!rst) prod_q[i] <= '0;
         else      prod_q[i] <= prod_d[i];
      end
   end

   // Stage 2: lane sum into the accumulator.
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < NUM_RAM_SPLITS; i++) begin
         lane_sum = lane_sum + ACC_WIDTH'(prod_q[i]);
      end
   end

   always_comb acc_clr = ((state_q == StIdle) && start) || (state_q == StWrite);

   always_ff @(posedge clk) begin
      if (!rst)         acc_q <= '0;
      else if (acc_clr) acc_q <= '0;
      else              acc_q <= acc_q + lane_sum;
   end

   // The bias address has been stable for the whole FETCH, so the word seen
   // in the first DRAIN cycle belongs to the current neuron.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bias_q <= '0;
      end else if ((state_q == StDrain) && !drain_q) begin
         bias_q <= bias_rd;
      end
   end

   // Result: arithmetic shift (floor), bias, optional ReLU, saturate.
   always_comb begin
      acc_shr  = acc_q >>> FRAC_BITS;
      res_full = acc_shr + ACC_WIDTH'(bias_q);
      if ((RELU != 0) && res_full[ACC_WIDTH-1]) res_full = '0;
      if (res_full > SatMax)      res = {1'b0, {(BIT_WIDTH - 1){1'b1}}};
      else if (res_full < SatMin) res = {1'b1, {(BIT_WIDTH - 1){1'b0}}};
      else                        res = res_full[BIT_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_wr_q <= '0;
         addr_wr_q <= '0;
      end else if (state_q == StWrite) begin
         data_wr_q <= res;
         addr_wr_q <= o_q;
      end
   end

endmodule
